// File: rtl/t07_spi_tft_writer.sv
// Write-only SPI serializer for the TFT port: takes a 1-4 byte MMIO write and shifts it out MSB first.
// Optional burst mode (cs_n held low between data writes) is enabled by defining T07_TFT_CS_HOLD_EN.
module t07_spi_tft_writer #(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned CS_GAP  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wi_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] data_in,
   output logic        ack_TFT,
   output logic        done,
   output logic        tft_sclk,
   output logic        tft_mosi,
   output logic        tft_cs_n,
   output logic        tft_dc
);
   localparam int unsigned DIV_LAST    = CLK_DIV - 1;
   localparam int unsigned GAP_LAST    = (CS_GAP > 0) ? CS_GAP - 1 : 0;
   localparam int unsigned LINGER_LAST = 15;

   typedef enum logic [2:0] {
      IDLE, SETUP, SHIFT, HOLD, GAP
`ifdef T07_TFT_CS_HOLD_EN
      , LINGER
`endif
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [4:0]  bit_cnt, bit_nxt;
   logic [31:0] shreg, sh_nxt;
   logic [1:0]  n_m1, nm1_nxt;
   logic        armed, armed_nxt;
   logic        fin, fin_nxt;
   logic        ack_nxt, done_nxt, sclk_nxt, mosi_nxt, cs_nxt, dc_nxt;
   logic        accept, take;
   logic [31:0] load_sh;
   logic [4:0]  term;
`ifdef T07_TFT_CS_HOLD_EN
   logic        pend, pend_nxt;
`endif

   logic unused_addr;
   assign unused_addr = ^{addr_in[31:5], addr_in[1:0]};

   // Left-align the used bytes so the first bit to send is always shreg[31].
   assign load_sh = data_in << {~addr_in[4:3], 3'b000};
   assign term    = {n_m1, 3'b111};
   assign accept  = wi_in & armed;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_cnt;
      sh_nxt    = shreg;
      nm1_nxt   = n_m1;
      armed_nxt = armed | ~wi_in;
      fin_nxt   = 1'b0;
      ack_nxt   = ack_TFT;
      done_nxt  = 1'b0;
      sclk_nxt  = tft_sclk;
      mosi_nxt  = tft_mosi;
      cs_nxt    = tft_cs_n;
      dc_nxt    = tft_dc;
      take      = 1'b0;
`ifdef T07_TFT_CS_HOLD_EN
      pend_nxt  = pend;
`endif
      // Completion is reported one cycle after cs_n releases.
      if (fin) begin
         ack_nxt  = 1'b0;
         done_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            if (accept) begin
               take      = 1'b1;
               cs_nxt    = 1'b0;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (cnt == 8'(DIV_LAST)) begin
               cnt_nxt   = 8'd0;
               state_nxt = SHIFT;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         SHIFT: begin
            if (cnt == 8'(DIV_LAST)) begin
               cnt_nxt = 8'd0;
               if (!tft_sclk) begin
                  sclk_nxt = 1'b1;
               end else begin
                  sclk_nxt = 1'b0;
                  if (bit_cnt == term) begin
                     state_nxt = HOLD;
                  end else begin
                     bit_nxt  = bit_cnt + 5'd1;
                     sh_nxt   = {shreg[30:0], 1'b0};
                     mosi_nxt = shreg[30];
                  end
               end
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         HOLD: begin
            if (cnt == 8'(DIV_LAST)) begin
               cnt_nxt  = 8'd0;
               mosi_nxt = 1'b0;
               fin_nxt  = 1'b1;
`ifdef T07_TFT_CS_HOLD_EN
               if (tft_dc) begin
                  state_nxt = LINGER;
               end else begin
                  cs_nxt    = 1'b1;
                  state_nxt = GAP;
               end
`else
               cs_nxt    = 1'b1;
               state_nxt = GAP;
`endif
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         GAP: begin
            if (cnt == 8'(GAP_LAST)) begin
               cnt_nxt   = 8'd0;
               state_nxt = IDLE;
`ifdef T07_TFT_CS_HOLD_EN
               // A command request taken during LINGER resumes here with a full setup.
               if (pend) begin
                  pend_nxt  = 1'b0;
                  cs_nxt    = 1'b0;
                  state_nxt = SETUP;
               end
`endif
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
`ifdef T07_TFT_CS_HOLD_EN
         LINGER: begin
            if (accept) begin
               take = 1'b1;
               if (addr_in[2]) begin
                  state_nxt = SHIFT;
               end else begin
                  cs_nxt    = 1'b1;
                  pend_nxt  = 1'b1;
                  state_nxt = GAP;
               end
            end else if (cnt == 8'(LINGER_LAST)) begin
               cnt_nxt   = 8'd0;
               cs_nxt    = 1'b1;
               state_nxt = GAP;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase

      // Latch the request; later input changes are ignored until the next accept.
      if (take) begin
         sh_nxt    = load_sh;
         nm1_nxt   = addr_in[4:3];
         dc_nxt    = addr_in[2];
         mosi_nxt  = load_sh[31];
         sclk_nxt  = 1'b0;
         armed_nxt = 1'b0;
         ack_nxt   = 1'b1;
         bit_nxt   = 5'd0;
         cnt_nxt   = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         bit_cnt  <= 5'd0;
         shreg    <= 32'd0;
         n_m1     <= 2'd0;
         armed    <= 1'b1;
         fin      <= 1'b0;
         ack_TFT  <= 1'b0;
         done     <= 1'b0;
         tft_sclk <= 1'b0;
         tft_mosi <= 1'b0;
         tft_cs_n <= 1'b1;
         tft_dc   <= 1'b0;
`ifdef T07_TFT_CS_HOLD_EN
         pend     <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_cnt  <= bit_nxt;
         shreg    <= sh_nxt;
         n_m1     <= nm1_nxt;
         armed    <= armed_nxt;
         fin      <= fin_nxt;
         ack_TFT  <= ack_nxt;
         done     <= done_nxt;
         tft_sclk <= sclk_nxt;
         tft_mosi <= mosi_nxt;
         tft_cs_n <= cs_nxt;
         tft_dc   <= dc_nxt;
`ifdef T07_TFT_CS_HOLD_EN
         pend     <= pend_nxt;
`endif
      end
   end
endmodule
